// File: rtl/demux_1x4_buf.sv
// rtl/demux_1x4_buf.sv - registered 1-to-4 demultiplexer with per-channel holding register and saturating word counter
module demux_1x4_buf #(
   parameter int W  = 8,
   parameter int CW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    in_data,
   input  logic [1:0]      in_sel,
   output logic [3:0]      out_valid,
   input  logic [3:0]      out_ready,
   output logic [4*W-1:0]  out_data,
   input  logic            cnt_clr,
   output logic [4*CW-1:0] cnt
);

   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   logic [3:0]    r_full;
   logic [W-1:0]  r_data [4];
   logic [CW-1:0] r_cnt  [4];

   logic [3:0]    w_drain;
   logic [3:0]    w_sel_dec;
   logic [3:0]    w_load;
   logic          w_accept;

   // Handshake decode: a full channel that drains this cycle can take a new word
   // in the same cycle, giving one word per cycle per channel. The selected
   // channel blocks the whole input when it is full and not draining.
   always_comb begin
      w_drain   = r_full & out_ready;
      w_sel_dec = 4'b0001 << in_sel;
      in_ready  = rst_n & (~r_full[in_sel] | w_drain[in_sel]);
      w_accept  = in_valid & in_ready;
      w_load    = w_accept ? w_sel_dec : 4'b0000;
   end

   // Channel holding registers and counters; counter clear wins over increment
   // but never blocks the data load itself.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_full <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            r_data[i] <= '0;
            r_cnt[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (w_load[i]) begin
               r_full[i] <= 1'b1;
               r_data[i] <= in_data;
            end else if (w_drain[i]) begin
               r_full[i] <= 1'b0;
            end

            if (cnt_clr) begin
               r_cnt[i] <= '0;
            end else if (w_load[i] && (r_cnt[i] != CNT_MAX)) begin
               r_cnt[i] <= r_cnt[i] + CNT_ONE;
            end
         end
      end
   end

   // Flatten per-channel registers onto the packed output buses.
   always_comb begin
      out_valid = r_full;
      out_data  = '0;
      cnt       = '0;
      for (int i = 0; i < 4; i++) begin
         out_data[i*W +: W] = r_data[i];
         cnt[i*CW +: CW]    = r_cnt[i];
      end
   end

endmodule

// File: tb/tb_demux_1x4_buf.sv
// tb/tb_demux_1x4_buf.sv - table-driven self-checking bench for demux_1x4_buf
module tb_demux_1x4_buf;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic [1:0]  in_sel;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [31:0] out_data;
   logic        cnt_clr;
   logic [31:0] cnt;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        rst_n;
      logic        iv;
      logic [1:0]  sel;
      logic [7:0]  d;
      logic [3:0]  ordy;
      logic        clr;
      logic        chk_rdy;
      logic        exp_rdy;
      logic [3:0]  exp_ov;
      logic [31:0] exp_od;
      logic [31:0] exp_cnt;
   } vec_t;

   vec_t vecs[$];

   demux_1x4_buf #(.W(8), .CW(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .cnt_clr(cnt_clr), .cnt(cnt)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic iv, input logic [1:0] sel,
                               input logic [7:0] d, input logic [3:0] ordy, input logic clr,
                               input logic chk, input logic rdy, input logic [3:0] ov,
                               input logic [31:0] od, input logic [31:0] c);
      vec_t v;
      v.rst_n = r; v.iv = iv; v.sel = sel; v.d = d; v.ordy = ordy; v.clr = clr;
      v.chk_rdy = chk; v.exp_rdy = rdy; v.exp_ov = ov; v.exp_od = od; v.exp_cnt = c;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst_n     = v.rst_n;
      in_valid  = v.iv;
      in_sel    = v.sel;
      in_data   = v.d;
      out_ready = v.ordy;
      cnt_clr   = v.clr;
   endtask

   // Drive one cycle's inputs, check in_ready before the edge, then outputs after it.
   task automatic step(input string tag, input vec_t v);
      drive(v);
      #1;
      if (v.chk_rdy) check({tag, " in_ready"}, {31'b0, in_ready}, {31'b0, v.exp_rdy});
      @(posedge clk);
      #1;
      check({tag, " out_valid"}, {28'b0, out_valid}, {28'b0, v.exp_ov});
      check({tag, " out_data"}, out_data, v.exp_od);
      check({tag, " cnt"}, cnt, v.exp_cnt);
   endtask

   initial begin
      logic all_rdy;
      rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00;
      out_ready = 4'b0000; cnt_clr = 1'b0;

      // reset with in_valid high: nothing captured, in_ready low
      vecs.push_back(mk(0, 1, 2'd0, 8'hFF, 4'b0000, 0, 1, 0, 4'b0000, 32'h0, 32'h0));
      vecs.push_back(mk(0, 1, 2'd1, 8'hEE, 4'b0000, 0, 1, 0, 4'b0000, 32'h0, 32'h0));
      // route all four
      vecs.push_back(mk(1, 1, 2'd0, 8'hA0, 4'b0000, 0, 1, 1, 4'b0001, 32'h000000A0, 32'h00000001));
      vecs.push_back(mk(1, 1, 2'd1, 8'hA1, 4'b0000, 0, 1, 1, 4'b0011, 32'h0000A1A0, 32'h00000101));
      vecs.push_back(mk(1, 1, 2'd2, 8'hA2, 4'b0000, 0, 1, 1, 4'b0111, 32'h00A2A1A0, 32'h00010101));
      vecs.push_back(mk(1, 1, 2'd3, 8'hA3, 4'b0000, 0, 1, 1, 4'b1111, 32'hA3A2A1A0, 32'h01010101));
      // backpressure on channel 2, then release
      vecs.push_back(mk(1, 1, 2'd2, 8'h55, 4'b0000, 0, 1, 0, 4'b1111, 32'hA3A2A1A0, 32'h01010101));
      vecs.push_back(mk(1, 1, 2'd2, 8'h55, 4'b0100, 0, 1, 1, 4'b1111, 32'hA355A1A0, 32'h01020101));
      // drain everything, clear counters
      vecs.push_back(mk(1, 0, 2'd2, 8'h99, 4'b1111, 1, 0, 0, 4'b0000, 32'hA355A1A0, 32'h00000000));
      // stream 10 words to channel 1
      for (int k = 0; k < 10; k++) begin
         vecs.push_back(mk(1, 1, 2'd1, 8'h10 + 8'(k), 4'b1111, 0, 1, 1, 4'b0010,
                           {8'hA3, 8'h55, 8'h10 + 8'(k), 8'hA0}, {16'h0, 8'(k + 1), 8'h00}));
      end
      vecs.push_back(mk(1, 0, 2'd0, 8'h00, 4'b1111, 0, 0, 0, 4'b0000, 32'hA35519A0, 32'h00000A00));

      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) step($sformatf("v%0d", i), vecs[i]);

      // saturation: 300 accepts to channel 3 with channel 3 draining every cycle
      all_rdy = 1'b1;
      for (int k = 0; k < 300; k++) begin
         drive(mk(1, 1, 2'd3, 8'(k), 4'b1000, 0, 0, 0, 4'b0, 32'h0, 32'h0));
         #1;
         all_rdy = all_rdy & in_ready;
         @(posedge clk);
         #1;
         if (k == 254) check("sat cnt at 255 accepts", cnt, 32'hFF000A00);
      end
      check("sat in_ready stayed high", {31'b0, all_rdy}, 32'h1);
      check("sat cnt no wrap", cnt, 32'hFF000A00);

      // clear with simultaneous accept: word delivered, counters zero
      step("clr+accept", mk(1, 1, 2'd3, 8'h77, 4'b1000, 1, 1, 1, 4'b1000, 32'h775519A0, 32'h0));

      // mid-operation reset with channels 0 and 3 full
      step("fill ch0", mk(1, 1, 2'd0, 8'h11, 4'b0000, 0, 1, 1, 4'b1001, 32'h77551911, 32'h00000001));
      step("mid reset", mk(0, 1, 2'd0, 8'h33, 4'b0000, 0, 1, 0, 4'b0000, 32'h0, 32'h0));
      step("post reset", mk(1, 1, 2'd0, 8'h22, 4'b0000, 0, 1, 1, 4'b0001, 32'h00000022, 32'h00000001));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/demux_1x4_buf.md
Name: demux_1x4_buf

Overview:
- Registered 1-to-4 demultiplexer: the inverse of the team's 4x1 mux.
- Takes one valid/ready input stream tagged with a 2-bit select (S1:S0) and delivers each word to exactly one of four output channels.
- Each output channel has a one-entry holding register and a saturating per-channel word counter.
- Sits between a shared source and four independent consumers, each of which may back-pressure.

Parameters:
- W, 8, data width in bits of the input word and of each output channel.
- CW, 8, width of each per-channel accepted-word counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the word on in_data/in_sel this cycle.
- in_data  input  W  input word.
- in_sel  input  2  destination channel; {S1,S0}; 0..3 selects channel 0..3.
- out_valid  output  4  bit i = channel i holds a word.
- out_ready  input  4  bit i = consumer i takes the word this cycle.
- out_data  output  4*W  channel i data at bits [i*W +: W].
- cnt_clr  input  1  synchronous clear of all counters.
- cnt  output  4*CW  channel i accepted-word count at bits [i*CW +: CW].

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - out_valid=4'b0000, out_data=0, cnt=0.
  - Any held words are discarded; no handshake completes in that cycle.
  - Reset takes priority over every other event.
- Per-channel state is full_i, which equals out_valid[i].
- Drain: drain_i = out_valid[i] & out_ready[i].
- in_ready is combinational: in_ready = ~full[in_sel] | drain[in_sel].
  - in_ready depends on in_sel and out_ready; it is evaluated only while in_valid=1.
  - in_ready is 0 while rst_n=0.
- Accept: accept = in_valid & in_ready.
  - On accept, channel in_sel loads in_data, and out_valid[in_sel] is 1 on the next cycle.
  - Latency: exactly 1 cycle from accept to visibility on out_data.
- Channel i update each rising edge (not in reset):
  - accept to i and drain_i: register reloads with the new word, full stays 1. This gives full throughput of 1 word/cycle per channel.
  - accept to i only: load, full_i=1.
  - drain_i only: full_i=0. The data register holds its old value; it is don't-care while invalid.
  - neither: hold.
- Non-selected channels are unaffected by an accept and drain independently.
  - All four channels may drain in the same cycle.
- Backpressure: if channel in_sel is full and not draining, in_ready=0.
  - The word is not taken and the source must hold in_data/in_sel stable.
  - Other channels keep draining.
  - There is no head-of-line bypass: a blocked select stalls the input even if other channels are empty.
- Output stability: while out_valid[i]=1 and out_ready[i]=0, out_data channel i is held constant.
- in_valid=0: in_sel and in_data are ignored; no state changes except drains.
- Counters: cnt_i increments by 1 on each accept to channel i.
  - Saturates at 2^CW-1 with no wrap.
  - cnt_clr=1 sets all counters to 0 and has priority over a same-cycle increment; the accept itself still completes.
- No combinational path from in_data to any output.

Test Plan:
- Reset then idle:
  - Hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0000, cnt all 0, in_ready=0 during reset, nothing captured.
- Route all four:
  - Send 8'hA0,A1,A2,A3 with in_sel=0,1,2,3 on consecutive cycles, out_ready=0000.
  - -> out_valid=1111 and channel i data=A0+i, each 1 cycle after its accept. cnt = 1,1,1,1.
- Backpressure:
  - With channel 2 full and out_ready[2]=0, drive in_sel=2, data=8'h55 -> in_ready=0 and channel 2 still holds A2.
  - Raise out_ready[2] -> same cycle in_ready=1; next cycle channel 2 = 8'h55, out_valid[2]=1, cnt2=2.
- Streaming:
  - out_ready=1111; send 10 words to channel 1, one per cycle -> in_ready stays 1, channel 1 shows each word exactly 1 cycle later, cnt1=10.
- Saturation and clear:
  - CW=8; 300 accepts to channel 3 -> cnt3=255.
  - cnt_clr with a simultaneous accept -> cnt3=0 next cycle and the word is delivered.
- Mid-operation reset:
  - Channels 0 and 3 full; assert rst_n=0 for 1 cycle -> out_valid=0000, cnt=0.
  - The next accepted word to channel 0 appears normally.
